// File: rtl/user_io_pkg.sv
// Shared types, state encoding, LED request codes and default timing for the user I/O controller.
package user_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    typedef logic [1:0] mode_t;

    localparam int TIMER_W = 27;

    localparam logic [3:0] LED_SOLID     = 4'b0001;
    localparam logic [3:0] LED_ARMED_ADD = 4'b0100;
    localparam logic [3:0] LED_ACK       = 4'b1111;

    localparam int DEF_ARM_TIMEOUT = 100000000;
    localparam int DEF_ACK_CYCLES  = 25000000;
    localparam int DEF_LONG_CYCLES = 50000000;

    function automatic logic [3:0] led_code(input logic [1:0] st, input mode_t m);
        logic [3:0] code;
        code = LED_SOLID << m;
        case (st)
            ST_ARMED: code = code | LED_ARMED_ADD;
            ST_ACK:   code = LED_ACK;
            default:  code = LED_SOLID << m;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/user_io_if.sv
// Button inputs and LED/action outputs of the user I/O controller.
interface user_io_if;
    import user_io_pkg::*;

    logic [1:0] btn_pressed;
    logic [1:0] btn_held;
    logic [3:0] led_pattern;
    mode_t      mode;
    logic       action_strobe;
    mode_t      action_mode;
    logic [1:0] state_dbg;

    modport master (
        output btn_pressed, btn_held,
        input  led_pattern, mode, action_strobe, action_mode, state_dbg
    );

    modport slave (
        input  btn_pressed, btn_held,
        output led_pattern, mode, action_strobe, action_mode, state_dbg
    );
endinterface

// File: rtl/user_io_hold_det.sv
// Long-press detector: counts a continuous hold and emits one pulse per hold.
// The pulse is combinational from registered state so the consumer's register sees it on the qualifying edge.
module user_io_hold_det
    import user_io_pkg::*;
#(
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic held,
    output logic long_press
);
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LONG_CYCLES - 1);

    logic [TIMER_W-1:0] hold_cnt;
    logic               fired;

    assign long_press = held && (hold_cnt == LAST) && !fired;

    // Counter parks at LAST; the fired flag keeps it to one pulse until release.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
            fired    <= 1'b0;
        end else if (!held) begin
            hold_cnt <= '0;
            fired    <= 1'b0;
        end else begin
            if (hold_cnt != LAST) hold_cnt <= hold_cnt + 1'b1;
            if (long_press)       fired    <= 1'b1;
        end
    end
endmodule

// File: rtl/user_io_ctrl.sv
// Mode select / arm / confirm FSM with state timer; all outputs registered one cycle after the input event.
module user_io_ctrl
    import user_io_pkg::*;
#(
    parameter int ARM_TIMEOUT = DEF_ARM_TIMEOUT,
    parameter int ACK_CYCLES  = DEF_ACK_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic     clk,
    input  logic     reset,
    user_io_if.slave io
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ARMED = ST_ARMED;
    localparam logic [1:0] S_ACK   = ST_ACK;

    localparam logic [TIMER_W-1:0] ARM_LOAD = TIMER_W'(ARM_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ACK_LOAD = TIMER_W'(ACK_CYCLES - 1);

    logic [1:0]         state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    mode_t              mode, mode_n;
    mode_t              amode, amode_n;
    logic               strobe, strobe_n;
    logic [3:0]         led;
    logic               long_press;

    user_io_hold_det #(.LONG_CYCLES(LONG_CYCLES)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .held       (io.btn_held[0]),
        .long_press (long_press)
    );

    always_comb begin
        state_n  = state;
        timer_n  = (timer != '0) ? timer - 1'b1 : '0;
        mode_n   = mode;
        amode_n  = amode;
        strobe_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (long_press)
                    mode_n = 2'd0;
                else if (io.btn_pressed[0] && !io.btn_pressed[1])
                    mode_n = mode + 2'd1;
                if (io.btn_pressed[1]) begin
                    state_n = S_ARMED;
                    timer_n = ARM_LOAD;
                end
            end
            S_ARMED: begin
                if (long_press) begin
                    mode_n  = 2'd0;
                    state_n = S_IDLE;
                end else if (io.btn_pressed[1]) begin
                    strobe_n = 1'b1;
                    amode_n  = mode;
                    state_n  = S_ACK;
                    timer_n  = ACK_LOAD;
                end else if (io.btn_pressed[0] || timer == '0) begin
                    state_n = S_IDLE;
                end
            end
            S_ACK: begin
                if (timer == '0) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            timer  <= '0;
            mode   <= 2'd0;
            amode  <= 2'd0;
            strobe <= 1'b0;
            led    <= LED_SOLID;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            mode   <= mode_n;
            amode  <= amode_n;
            strobe <= strobe_n;
            led    <= led_code(state_n, mode_n);
        end
    end

    assign io.led_pattern   = led;
    assign io.mode          = mode;
    assign io.action_strobe = strobe;
    assign io.action_mode   = amode;
    assign io.state_dbg     = state;
endmodule

// File: tb/tb_user_io_ctrl.sv
// Directed bench for user_io_ctrl with a cycle-count model checked on every falling edge.
module tb_user_io_ctrl;
    import user_io_pkg::*;

    localparam int ARM   = 8;
    localparam int ACKC  = 4;
    localparam int LONGC = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    user_io_if io();

    user_io_ctrl #(
        .ARM_TIMEOUT (ARM),
        .ACK_CYCLES  (ACKC),
        .LONG_CYCLES (LONGC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int seq_mode [5] = '{1, 2, 3, 0, 1};

    // Model: state name, mode, cycles remaining in the current timed state, held-cycle count.
    int m_state = 0, m_mode = 0, m_left = 0, m_hold = 0;
    bit m_fired = 1'b0;
    int e_strobe = 0, e_amode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_led();
        case (m_state)
            0:       return 1 << m_mode;
            1:       return (1 << m_mode) | 4;
            default: return 15;
        endcase
    endfunction

    always @(posedge clk) begin
        bit p0, p1, h, longp;
        p0 = io.btn_pressed[0];
        p1 = io.btn_pressed[1];
        h  = io.btn_held[0];
        e_strobe = 0;
        if (reset) begin
            m_state = 0; m_mode = 0; m_left = 0; m_hold = 0; m_fired = 0; e_amode = 0;
        end else begin
            m_hold = h ? ((m_hold < LONGC) ? m_hold + 1 : m_hold) : 0;
            longp  = h && (m_hold == LONGC) && !m_fired;
            if (longp) m_fired = 1;
            if (!h)    m_fired = 0;
            case (m_state)
                0: begin
                    if (longp) m_mode = 0;
                    if (p1) begin
                        m_state = 1; m_left = ARM;
                    end else if (p0 && !longp) begin
                        m_mode = (m_mode + 1) % 4;
                    end
                end
                1: begin
                    if (longp) begin
                        m_mode = 0; m_state = 0;
                    end else if (p1) begin
                        e_strobe = 1; e_amode = m_mode; m_state = 2; m_left = ACKC;
                    end else if (p0) begin
                        m_state = 0;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_state = 0;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_state = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_mode",   io.mode,          m_mode);
            chk("model_led",    io.led_pattern,   exp_led());
            chk("model_state",  io.state_dbg,     m_state);
            chk("model_strobe", io.action_strobe, e_strobe);
            chk("model_amode",  io.action_mode,   e_amode);
        end
    end

    task automatic cyc(input logic r, input logic [1:0] p, input logic h);
        @(negedge clk);
        reset          = r;
        io.btn_pressed = p;
        io.btn_held    = {1'b0, h};
    endtask

    initial begin
        int cnt, cnt2;
        io.btn_pressed = 2'b00;
        io.btn_held    = 2'b00;
        @(posedge clk);
        chk_en = 1'b1;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        chk("reset_mode",  io.mode, 0);
        chk("reset_led",   io.led_pattern, 4'b0001);
        chk("reset_state", io.state_dbg, 0);
        chk("reset_amode", io.action_mode, 0);

        // Mode stepping with wrap
        for (int i = 0; i < 5; i++) begin
            cyc(0, 2'b01, 0);
            cyc(0, 2'b00, 0);
            chk("seq_mode", io.mode, seq_mode[i]);
        end
        chk("mode1_led", io.led_pattern, 4'b0010);

        // Arm then confirm
        cyc(0, 2'b10, 0);
        cyc(0, 2'b00, 0);
        chk("armed_led", io.led_pattern, 4'b0110);
        cyc(0, 2'b00, 0);
        cyc(0, 2'b10, 0);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 2'b00, 0);
            if (i == 0) chk("confirm_amode", io.action_mode, 1);
            cnt  += int'(io.action_strobe);
            cnt2 += int'(io.led_pattern == 4'b1111);
        end
        chk("confirm_strobes", cnt, 1);
        chk("ack_led_cycles", cnt2, 4);
        chk("confirm_idle", io.state_dbg, 0);

        // Arm timeout
        cyc(0, 2'b10, 0);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 2'b00, 0);
            cnt  += int'(io.state_dbg == 2'd1);
            cnt2 += int'(io.action_strobe);
        end
        chk("armed_cycles", cnt, 8);
        chk("timeout_strobes", cnt2, 0);

        // Both buttons: arm in IDLE, confirm in ARMED
        cyc(0, 2'b11, 0);
        cyc(0, 2'b00, 0);
        chk("both_idle_state", io.state_dbg, 1);
        chk("both_idle_mode", io.mode, 1);
        cyc(0, 2'b11, 0);
        cyc(0, 2'b00, 0);
        chk("both_armed_strobe", io.action_strobe, 1);
        repeat (5) cyc(0, 2'b00, 0);

        // Long press, then re-increment during the same hold must stick
        cyc(0, 2'b01, 0);
        cyc(0, 2'b00, 0);
        chk("pre_hold_mode", io.mode, 2);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, (i == 8) ? 2'b01 : 2'b00, 1);
            if (i == 6) chk("hold5_mode", io.mode, 2);
            if (i == 7) chk("hold6_mode", io.mode, 0);
        end
        cyc(0, 2'b00, 0);
        chk("one_shot_mode", io.mode, 1);
        for (int i = 1; i <= 6; i++) cyc(0, (i == 6) ? 2'b01 : 2'b00, 1);
        cyc(0, 2'b00, 0);
        chk("long_over_inc", io.mode, 0);

        // Long press in ARMED returns to IDLE
        cyc(0, 2'b01, 0);
        cyc(0, 2'b00, 1);
        cyc(0, 2'b10, 1);
        repeat (4) cyc(0, 2'b00, 1);
        cyc(0, 2'b00, 0);
        chk("long_armed_state", io.state_dbg, 0);
        chk("long_armed_mode", io.mode, 0);

        // Long press in ACK ignored
        cyc(0, 2'b01, 0);
        cyc(0, 2'b10, 0);
        repeat (3) cyc(0, 2'b00, 1);
        cyc(0, 2'b10, 1);
        repeat (2) cyc(0, 2'b00, 1);
        cyc(0, 2'b00, 0);
        chk("long_ack_state", io.state_dbg, 2);
        chk("long_ack_mode", io.mode, 1);
        repeat (5) cyc(0, 2'b00, 0);

        // Reset mid-ACK and mid-ARMED
        cyc(0, 2'b10, 0);
        cyc(0, 2'b10, 0);
        cyc(0, 2'b00, 0);
        cyc(0, 2'b00, 0);
        cyc(1, 2'b00, 0);
        cyc(0, 2'b00, 0);
        chk("rst_ack_state", io.state_dbg, 0);
        chk("rst_ack_led", io.led_pattern, 4'b0001);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 2'b00, 0);
            cnt += int'(io.action_strobe);
        end
        chk("rst_ack_strobes", cnt, 0);
        cyc(0, 2'b10, 0);
        cyc(0, 2'b00, 0);
        cyc(1, 2'b10, 0);
        cyc(0, 2'b00, 0);
        chk("rst_armed_state", io.state_dbg, 0);
        chk("rst_armed_strobe", io.action_strobe, 0);
        repeat (3) cyc(0, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
